// File: rtl/gpio_input_pkg.sv
// Shared constants for the GPIO input conditioning block: board bit map,
// default input count and the millisecond tick divider helper.
package gpio_input_pkg;

   // Bit positions of the Nexys A7 buttons and the first slide switch
   localparam int BTN_R   = 0;
   localparam int BTN_L   = 1;
   localparam int BTN_D   = 2;
   localparam int BTN_U   = 3;
   localparam int BTN_C   = 4;
   localparam int SW_BASE = 5;

   // Five buttons plus sixteen switches
   localparam int NUM_IN_DEFAULT = 21;

   // Number of clk cycles in one millisecond
   function automatic int ms_to_ticks(input int freq_hz);
      return freq_hz / 1000;
   endfunction

endpackage

// File: rtl/gpio_input_debounce_cell.sv
// One conditioned input: two-flop synchroniser, tick-based debounce counter
// and registered rise/fall pulses. With GPIO_DEBOUNCE_REPEAT_EN defined a
// cell whose REPEAT_EN is set also emits auto-repeat rise pulses while held.
module debounce_cell
   import gpio_input_pkg::*;
#(
   parameter int DEBOUNCE_MS = 10
`ifdef GPIO_DEBOUNCE_REPEAT_EN
   ,parameter bit REPEAT_EN       = 1'b0
   ,parameter int REPEAT_DELAY_MS = 500
   ,parameter int REPEAT_RATE_MS  = 100
`endif
)(
   input  logic clk,
   input  logic resetn,
   input  logic raw_i,
   input  logic tick_i,
   output logic clean_o,
   output logic rise_o,
   output logic fall_o,
   output logic edge_nxt_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_clean;
   logic             r_rise;
   logic             r_fall;
   logic [CNT_W-1:0] r_cnt;

   logic w_agree;
   logic w_update;
   logic w_rep_pulse;
   logic w_rise_nxt;
   logic w_fall_nxt;

   // Bring the asynchronous pin into the clk domain
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw_i;
         r_sync2 <= r_sync1;
      end
   end

   // Decide when the stable level flips and what pulses that produces
   always_comb begin
      w_agree    = (r_sync2 == r_clean);
      w_update   = !w_agree && tick_i && (r_cnt == CNT_W'(DEBOUNCE_MS - 1));
      w_rise_nxt = (w_update && r_sync2) || w_rep_pulse;
      w_fall_nxt = w_update && !r_sync2;
   end

   // Count ticks of disagreement; any agreeing sample aborts the change
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt   <= {CNT_W{1'b0}};
         r_clean <= 1'b0;
      end else if (w_agree) begin
         r_cnt   <= {CNT_W{1'b0}};
      end else if (w_update) begin
         r_cnt   <= {CNT_W{1'b0}};
         r_clean <= r_sync2;
      end else if (tick_i) begin
         r_cnt   <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt   <= r_cnt;
      end
   end

   // Register edge pulses on the same edge that moves the stable level
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_rise_nxt;
         r_fall <= w_fall_nxt;
      end
   end

`ifdef GPIO_DEBOUNCE_REPEAT_EN
   if (REPEAT_EN) begin : g_rep
      localparam int REP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                               REPEAT_DELAY_MS : REPEAT_RATE_MS;
      localparam int REP_W   = $clog2(REP_MAX + 1);

      logic [REP_W-1:0] r_rep_cnt;
      logic             r_rep_first;
      logic             w_rep_hit;

      // First repeat waits the long delay, later ones the short rate
      always_comb begin
         if (r_rep_first) begin
            w_rep_hit = tick_i && r_clean && (r_rep_cnt == REP_W'(REPEAT_DELAY_MS - 1));
         end else begin
            w_rep_hit = tick_i && r_clean && (r_rep_cnt == REP_W'(REPEAT_RATE_MS - 1));
         end
      end

      // Tick counter that runs only while the debounced level is high
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            r_rep_cnt   <= {REP_W{1'b0}};
            r_rep_first <= 1'b1;
         end else if (!r_clean) begin
            r_rep_cnt   <= {REP_W{1'b0}};
            r_rep_first <= 1'b1;
         end else if (w_rep_hit) begin
            r_rep_cnt   <= {REP_W{1'b0}};
            r_rep_first <= 1'b0;
         end else if (tick_i) begin
            r_rep_cnt   <= r_rep_cnt + REP_W'(1);
         end else begin
            r_rep_cnt   <= r_rep_cnt;
         end
      end

      // A release landing on a repeat tick wins so rise and fall never overlap
      assign w_rep_pulse = w_rep_hit && !w_update;
   end else begin : g_norep
      assign w_rep_pulse = 1'b0;
   end
`else
   assign w_rep_pulse = 1'b0;
`endif

   assign clean_o    = r_clean;
   assign rise_o     = r_rise;
   assign fall_o     = r_fall;
   assign edge_nxt_o = w_rise_nxt | w_fall_nxt;

endmodule

// File: rtl/gpio_input_debounce.sv
// GPIO input conditioning between the board pins and the embedded system:
// one shared 1 ms prescaler, NUM_IN debounce cells and a registered
// "anything changed" strobe. Optional auto-repeat of rise pulses is compiled
// in with the macro GPIO_DEBOUNCE_REPEAT_EN.
module gpio_input_debounce
   import gpio_input_pkg::*;
#(
   parameter int                NUM_IN          = NUM_IN_DEFAULT,
   parameter int                CLK_FREQ_HZ     = 100_000_000,
   parameter int                DEBOUNCE_MS     = 10,
   parameter logic [NUM_IN-1:0] REPEAT_MASK     = 21'h0001F,
   parameter int                REPEAT_DELAY_MS = 500,
   parameter int                REPEAT_RATE_MS  = 100
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic [NUM_IN-1:0] raw_i,
   output logic [NUM_IN-1:0] clean_o,
   output logic [NUM_IN-1:0] rise_o,
   output logic [NUM_IN-1:0] fall_o,
   output logic              changed_o
);

   localparam int TICK_DIV = ms_to_ticks(CLK_FREQ_HZ);
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   if ((CLK_FREQ_HZ < 1000) || ((CLK_FREQ_HZ % 1000) != 0)) begin : g_bad_freq
      $error("gpio_input_debounce: CLK_FREQ_HZ must be a non-zero multiple of 1000");
   end
   if ((DEBOUNCE_MS < 1) || (DEBOUNCE_MS > 255)) begin : g_bad_debounce
      $error("gpio_input_debounce: DEBOUNCE_MS must be in 1..255");
   end
   if ((REPEAT_DELAY_MS < 1) || (REPEAT_RATE_MS < 1)) begin : g_bad_repeat
      $error("gpio_input_debounce: repeat intervals must be at least 1 ms");
   end

   logic [PRE_W-1:0]  r_pre;
   logic              r_changed;
   logic              w_tick;
   logic [NUM_IN-1:0] w_edge_nxt;

   // Tick on the last count of each millisecond
   always_comb begin
      w_tick = (r_pre == PRE_W'(TICK_DIV - 1));
   end

   // Free-running millisecond prescaler shared by every cell
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pre <= {PRE_W{1'b0}};
      end else if (w_tick) begin
         r_pre <= {PRE_W{1'b0}};
      end else begin
         r_pre <= r_pre + PRE_W'(1);
      end
   end

   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_MS     (DEBOUNCE_MS)
`ifdef GPIO_DEBOUNCE_REPEAT_EN
         ,.REPEAT_EN      (REPEAT_MASK[gi])
         ,.REPEAT_DELAY_MS(REPEAT_DELAY_MS)
         ,.REPEAT_RATE_MS (REPEAT_RATE_MS)
`endif
      ) u_cell (
         .clk       (clk),
         .resetn    (resetn),
         .raw_i     (raw_i[gi]),
         .tick_i    (w_tick),
         .clean_o   (clean_o[gi]),
         .rise_o    (rise_o[gi]),
         .fall_o    (fall_o[gi]),
         .edge_nxt_o(w_edge_nxt[gi])
      );
   end

   // Single strobe aligned with whichever cells pulse this cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |w_edge_nxt;
      end
   end

   assign changed_o = r_changed;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Self-checking bench for gpio_input_debounce: directed scenarios plus random
// toggling, all compared every cycle against a behavioural model that works
// from absolute edge numbers and tick arithmetic.
module tb_gpio_input_debounce;

   localparam int          NUM_IN = 21;
   localparam int          TD     = 10;
   localparam int          DB     = 3;
   localparam int          RD     = 5;
   localparam int          RR     = 2;
   localparam logic [20:0] MASK   = 21'h0001F;

   logic        clk = 1'b0;
   logic        resetn;
   logic [20:0] raw_i;
   logic [20:0] clean_o;
   logic [20:0] rise_o;
   logic [20:0] fall_o;
   logic        changed_o;

   always #5 clk = ~clk;

   gpio_input_debounce #(
      .NUM_IN         (NUM_IN),
      .CLK_FREQ_HZ    (10_000),
      .DEBOUNCE_MS    (DB),
      .REPEAT_MASK    (MASK),
      .REPEAT_DELAY_MS(RD),
      .REPEAT_RATE_MS (RR)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .raw_i    (raw_i),
      .clean_o  (clean_o),
      .rise_o   (rise_o),
      .fall_o   (fall_o),
      .changed_o(changed_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int          edge_n;
   logic [20:0] hist[$];
   logic [20:0] m_clean, m_rise, m_fall;
   logic        m_chg;
   bit          m_streak[NUM_IN];
   int          m_start[NUM_IN];
   int          m_ticks[NUM_IN];
   int          m_rise_at[NUM_IN];

   task automatic model_reset();
      edge_n = 0;
      hist.delete();
      m_clean = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         m_streak[i] = 1'b0; m_start[i] = 0; m_ticks[i] = 0; m_rise_at[i] = 0;
      end
   endtask

   // One rising edge: the level seen by the debouncer is the pin two edges ago;
   // a change lands on the tick edge where the disagreeing run holds DB ticks.
   task automatic model_step(input logic [20:0] raw);
      logic [20:0] s;
      bit          tk;
      bit          was;
      int          t;
      edge_n++;
      hist.push_back(raw);
      s = (hist.size() >= 3) ? hist[hist.size()-3] : 21'h0;
      if (hist.size() > 3) void'(hist.pop_front());
      tk = ((edge_n % TD) == 0);
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         was = m_clean[i];
         if (s[i] == m_clean[i]) begin
            m_streak[i] = 1'b0;
            m_ticks[i]  = 0;
         end else begin
            if (!m_streak[i]) begin
               m_streak[i] = 1'b1;
               m_start[i]  = edge_n;
            end
            m_ticks[i] = edge_n / TD - (m_start[i] - 1) / TD;
            if (tk && m_ticks[i] == DB) begin
               m_clean[i]  = s[i];
               m_streak[i] = 1'b0;
               m_ticks[i]  = 0;
               if (s[i]) begin
                  m_rise[i]    = 1'b1;
                  m_rise_at[i] = edge_n;
               end else begin
                  m_fall[i] = 1'b1;
               end
            end
         end
`ifdef GPIO_DEBOUNCE_REPEAT_EN
         if (MASK[i] && was && !m_fall[i] && tk) begin
            t = edge_n / TD - m_rise_at[i] / TD;
            if (t >= RD && ((t - RD) % RR) == 0) m_rise[i] = 1'b1;
         end
`else
         t = was ? 1 : 0;
`endif
      end
      m_chg = |(m_rise | m_fall);
   endtask

   // ---------------- cycle driver and pulse counters ----------------
   int c_rise[NUM_IN];
   int c_fall[NUM_IN];
   int c_chg;
   int cyc = 0;

   task automatic clear_counts();
      for (int i = 0; i < NUM_IN; i++) begin
         c_rise[i] = 0; c_fall[i] = 0;
      end
      c_chg = 0;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (resetn) model_step(raw_i);
      @(negedge clk);
      chk("clean_o", {11'h0, clean_o}, {11'h0, m_clean});
      chk("rise_o", {11'h0, rise_o}, {11'h0, m_rise});
      chk("fall_o", {11'h0, fall_o}, {11'h0, m_fall});
      chk("changed_o", {31'h0, changed_o}, {31'h0, m_chg});
      for (int i = 0; i < NUM_IN; i++) begin
         c_rise[i] += int'(rise_o[i]);
         c_fall[i] += int'(fall_o[i]);
      end
      c_chg += int'(changed_o);
      cyc++;
   endtask

   task automatic measure(input int b, input logic lvl, output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         cycle();
         if (lat < 0 && clean_o[b] == lvl) lat = k;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, lat20, total, coinc, b, dur;
      int q[$];

      resetn = 1'b0;
      raw_i  = '0;
      model_reset();
      clear_counts();
      repeat (3) cycle();
      resetn = 1'b1;

      // 1: idle after reset
      clear_counts();
      repeat (200) cycle();
      total = 0;
      for (int i = 0; i < NUM_IN; i++) total += c_rise[i] + c_fall[i];
      chk("t1_pulses", total, 0);
      chk("t1_changed", c_chg, 0);

      // 2: single press and release on bit 0
      clear_counts();
      raw_i[0] = 1'b1;
      measure(0, 1'b1, lat);
      chk("t2_rise_lat_in_23_32", (lat >= 23 && lat <= 32), 1);
      chk("t2_rise_cnt", c_rise[0], 1);
      chk("t2_changed_cnt", c_chg, 1);
      clear_counts();
      raw_i[0] = 1'b0;
      measure(0, 1'b0, lat);
      chk("t2_fall_lat_in_23_32", (lat >= 23 && lat <= 32), 1);
      chk("t2_fall_cnt", c_fall[0], 1);
      chk("t2_fall_rise_cnt", c_rise[0], 0);

      // 3: bouncing bit 3 and a short glitch on bit 10
      clear_counts();
      for (int k = 0; k < 100; k++) begin
         if (k % 5 == 0) raw_i[3] = ~raw_i[3];
         if (k == 20) raw_i[10] = 1'b1;
         if (k == 35) raw_i[10] = 1'b0;
         cycle();
      end
      raw_i[3] = 1'b1;
      repeat (40) cycle();
      chk("t3_rise3_cnt", c_rise[3], 1);
      chk("t3_fall3_cnt", c_fall[3], 0);
      chk("t3_clean3", clean_o[3], 1);
      chk("t3_glitch10", c_rise[10] + c_fall[10], 0);
      raw_i[3] = 1'b0;
      repeat (40) cycle();

      // 4: simultaneous change on bits 4 and 20
      clear_counts();
      raw_i[4]  = 1'b1;
      raw_i[20] = 1'b1;
      coinc = 0;
      for (int k = 0; k < 40; k++) begin
         cycle();
         if (rise_o[4] && rise_o[20]) coinc++;
      end
      chk("t4_coincident", coinc, 1);
      chk("t4_rise4", c_rise[4], 1);
      chk("t4_rise20", c_rise[20], 1);
      chk("t4_changed_cnt", c_chg, 1);
      raw_i[4]  = 1'b0;
      raw_i[20] = 1'b0;
      repeat (40) cycle();

      // 6: long hold on bit 0 (repeat-eligible) and bit 5 (not eligible)
      clear_counts();
      raw_i[0] = 1'b1;
      raw_i[5] = 1'b1;
      for (int k = 0; k < 150; k++) begin
         cycle();
         if (rise_o[0]) q.push_back(cyc);
      end
      chk("t6_rise5_cnt", c_rise[5], 1);
`ifdef GPIO_DEBOUNCE_REPEAT_EN
      chk("t6_repeat_count_ge3", (q.size() >= 3), 1);
      if (q.size() >= 3) begin
         chk("t6_first_repeat_gap", q[1] - q[0], RD * TD);
         chk("t6_next_repeat_gap", q[2] - q[1], RR * TD);
      end
`else
      chk("t6_rise0_cnt", c_rise[0], 1);
`endif
      raw_i[0] = 1'b0;
      raw_i[5] = 1'b0;
      repeat (40) cycle();

      // 5: asynchronous reset with a change pending on bit 1
      raw_i[20] = 1'b1;
      repeat (40) cycle();
      chk("t5_pre_clean20", clean_o[20], 1);
      raw_i[1] = 1'b1;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         cycle();
         if (m_ticks[1] == 2) begin
            lat = k;
            break;
         end
      end
      chk("t5_cnt2_reached", (lat > 0), 1);
      #1;
      resetn = 1'b0;
      model_reset();
      #1;
      chk("t5_async_clean", {11'h0, clean_o}, 32'h0);
      chk("t5_async_rise", {11'h0, rise_o}, 32'h0);
      chk("t5_async_fall", {11'h0, fall_o}, 32'h0);
      chk("t5_async_changed", {31'h0, changed_o}, 32'h0);
      repeat (3) cycle();
      resetn = 1'b1;
      clear_counts();
      lat20 = -1;
      lat   = -1;
      for (int k = 1; k <= 40; k++) begin
         cycle();
         if (lat < 0 && clean_o[1]) lat = k;
         if (lat20 < 0 && clean_o[20]) lat20 = k;
      end
      chk("t5_restart_lat1", lat, 30);
      chk("t5_restart_lat20", lat20, 30);
      chk("t5_rise1_cnt", c_rise[1], 1);
      raw_i[1]  = 1'b0;
      raw_i[20] = 1'b0;
      repeat (40) cycle();

      // Random toggling with one mid-run asynchronous reset
      for (int seg = 0; seg < 60; seg++) begin
         b = $urandom_range(0, NUM_IN - 1);
         raw_i[b] = ~raw_i[b];
         if ($urandom_range(0, 3) == 0) begin
            b = $urandom_range(0, NUM_IN - 1);
            raw_i[b] = ~raw_i[b];
         end
         dur = $urandom_range(1, 45);
         if (seg == 30) begin
            #($urandom_range(1, 4));
            resetn = 1'b0;
            model_reset();
            repeat (2) cycle();
            resetn = 1'b1;
         end
         repeat (dur) cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
